// File: rtl/commit_goal_monitor.sv
// Run-control and commit-statistics monitor beside the commit stage.
// Optional stall watchdog enabled by defining RSD_COMMIT_WATCHDOG_EN.
module commit_goal_monitor #(
  parameter int COMMIT_WIDTH = 4,
  parameter int PC_WIDTH     = 16,
  parameter int GOAL_NUM     = 2,
  parameter int CNT_WIDTH    = 48,
  parameter int STALL_LIMIT  = 1024,
  localparam int GI_W = (GOAL_NUM > 1) ? $clog2(GOAL_NUM) : 1
) (
  input  logic                         clk,
  input  logic                         rstOut,
  input  logic                         start,
  input  logic                         abort,
  input  logic [31:0]                  maxCycles,
  input  logic [GOAL_NUM-1:0]          goalEnable,
  input  logic [GOAL_NUM*PC_WIDTH-1:0] goalPC,
  input  logic [COMMIT_WIDTH-1:0]      commit,
  input  logic [COMMIT_WIDTH-1:0]      commitMidZero,
  input  logic [PC_WIDTH-1:0]          lastPC,
  input  logic                         ack,
  output logic                         running,
  output logic                         done,
  output logic [2:0]                   doneReason,
  output logic [GI_W-1:0]              goalIndex,
  output logic [CNT_WIDTH-1:0]         cycleCount,
  output logic [CNT_WIDTH-1:0]         microOpCount,
  output logic [CNT_WIDTH-1:0]         isaOpCount
);

  localparam int PW = $clog2(COMMIT_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [PW-1:0]   n_uop, n_isa;
  logic            goal_hit;
  logic [GI_W-1:0] goal_idx;
  logic [31:0]     cyc_lo;
  logic            timeout_hit;
  logic            stall_hit;
  logic [2:0]      reason_d;

  function automatic logic [CNT_WIDTH-1:0] sat_add(
    input logic [CNT_WIDTH-1:0] a,
    input logic [PW-1:0]        b
  );
    logic [CNT_WIDTH:0] s;
    s = {1'b0, a} + (CNT_WIDTH+1)'(b);
    return s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
  endfunction

  always_comb begin
    n_uop = '0;
    n_isa = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      n_uop = n_uop + PW'(commit[i]);
      n_isa = n_isa + PW'(commit[i] & commitMidZero[i]);
    end
  end

  // Scan downward so the lowest matching channel wins.
  always_comb begin
    goal_hit = 1'b0;
    goal_idx = '0;
    for (int g = GOAL_NUM - 1; g >= 0; g--) begin
      if (goalEnable[g] && |commit &&
          lastPC == goalPC[g*PC_WIDTH +: PC_WIDTH]) begin
        goal_hit = 1'b1;
        goal_idx = GI_W'(g);
      end
    end
  end

  if (CNT_WIDTH >= 32) begin : g_lo_wide
    assign cyc_lo = cycleCount[31:0];
  end else begin : g_lo_narrow
    assign cyc_lo = {{(32-CNT_WIDTH){1'b0}}, cycleCount};
  end

  assign timeout_hit = (maxCycles != 32'd0) &&
                       (cyc_lo + 32'd1 == maxCycles);

`ifdef RSD_COMMIT_WATCHDOG_EN
  localparam int IW = $clog2(STALL_LIMIT + 1);

  logic [IW-1:0] idle_cnt;

  assign stall_hit = ~|commit &&
                     (idle_cnt == IW'(STALL_LIMIT - 1));

  always_ff @(posedge clk or negedge rstOut) begin
    if (!rstOut) begin
      idle_cnt <= '0;
    end else if (state_q == IDLE && start) begin
      idle_cnt <= '0;
    end else if (state_q == RUN) begin
      idle_cnt <= |commit ? '0 : idle_cnt + IW'(1);
    end
  end
`else
  // No watchdog is built; a non-negative limit never fires.
  assign stall_hit = (STALL_LIMIT < 0);
`endif

  always_comb begin
    state_d  = state_q;
    reason_d = 3'd0;
    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        priority case (1'b1)
          abort:       reason_d = 3'd3;
          goal_hit:    reason_d = 3'd1;
          timeout_hit: reason_d = 3'd2;
          stall_hit:   reason_d = 3'd4;
          default:     reason_d = 3'd0;
        endcase
        if (reason_d != 3'd0) state_d = DONE;
      end
      DONE: if (ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstOut) begin
    if (!rstOut) begin
      state_q      <= IDLE;
      doneReason   <= 3'd0;
      goalIndex    <= '0;
      cycleCount   <= '0;
      microOpCount <= '0;
      isaOpCount   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        doneReason   <= 3'd0;
        goalIndex    <= '0;
        cycleCount   <= '0;
        microOpCount <= '0;
        isaOpCount   <= '0;
      end else if (state_q == RUN) begin
        cycleCount   <= sat_add(cycleCount, PW'(1));
        microOpCount <= sat_add(microOpCount, n_uop);
        isaOpCount   <= sat_add(isaOpCount, n_isa);
        if (state_d == DONE) begin
          doneReason <= reason_d;
          goalIndex  <= (reason_d == 3'd1) ? goal_idx : '0;
        end
      end
    end
  end

  assign running = (state_q == RUN);
  assign done    = (state_q == DONE);

endmodule

// File: tb/tb_commit_goal_monitor.sv
// Directed bench for commit_goal_monitor: counting, goals,
// priority, timeout, saturation, handshake, reset, watchdog.
module tb_commit_goal_monitor;

  logic        clk = 1'b0;
  logic        rstOut;
  logic        start, abort, ack;
  logic [31:0] maxCycles;
  logic [1:0]  goalEnable;
  logic [31:0] goalPC;
  logic [3:0]  commit, commitMidZero;
  logic [15:0] lastPC;

  logic        running, done;
  logic [2:0]  reason;
  logic [0:0]  gidx;
  logic [47:0] cyc, uop, isa;

  logic        s_running, s_done;
  logic [2:0]  s_reason;
  logic [0:0]  s_gidx;
  logic [3:0]  s_cyc, s_uop, s_isa;

  int cmp = 0;
  int err = 0;

  always #5 clk = ~clk;

  commit_goal_monitor #(
    .STALL_LIMIT(8)
  ) dut (
    .clk(clk), .rstOut(rstOut), .start(start), .abort(abort),
    .maxCycles(maxCycles), .goalEnable(goalEnable),
    .goalPC(goalPC), .commit(commit),
    .commitMidZero(commitMidZero), .lastPC(lastPC), .ack(ack),
    .running(running), .done(done), .doneReason(reason),
    .goalIndex(gidx), .cycleCount(cyc),
    .microOpCount(uop), .isaOpCount(isa)
  );

  commit_goal_monitor #(
    .CNT_WIDTH(4),
    .STALL_LIMIT(8)
  ) dut_s (
    .clk(clk), .rstOut(rstOut), .start(start), .abort(abort),
    .maxCycles(maxCycles), .goalEnable(goalEnable),
    .goalPC(goalPC), .commit(commit),
    .commitMidZero(commitMidZero), .lastPC(lastPC), .ack(ack),
    .running(s_running), .done(s_done), .doneReason(s_reason),
    .goalIndex(s_gidx), .cycleCount(s_cyc),
    .microOpCount(s_uop), .isaOpCount(s_isa)
  );

  task automatic quiet();
    start = 1'b0; abort = 1'b0; ack = 1'b0;
    commit = 4'h0; commitMidZero = 4'h0; lastPC = 16'h0;
  endtask

  task automatic go();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_ack();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    cmp++;
    if ({running, done, reason, gidx} !== 6'd0) begin
      err++;
      $display("FAIL reset_flags: got %b want 0",
               {running, done, reason, gidx});
    end
    cmp++;
    if ({cyc, uop, isa} !== 144'd0) begin
      err++;
      $display("FAIL reset_cnt: got %0h/%0h/%0h want 0",
               cyc, uop, isa);
    end
    rstOut = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_count();
    maxCycles = 0; goalEnable = 2'b00;
    go();
    commit = 4'hF; commitMidZero = 4'h5;
    repeat (10) @(negedge clk);
    cmp++;
    if (running !== 1'b1 || cyc !== 48'd10) begin
      err++;
      $display("FAIL count_mid: got run=%b cyc=%0d want 1/10",
               running, cyc);
    end
    commit = 4'h0; abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    cmp++;
    if (done !== 1'b1 || running !== 1'b0 || reason !== 3'd3) begin
      err++;
      $display("FAIL count_done: got d=%b r=%b rsn=%0d want 1/0/3",
               done, running, reason);
    end
    cmp++;
    if (cyc !== 48'd11 || uop !== 48'd40 || isa !== 48'd20) begin
      err++;
      $display("FAIL count_vals: got %0d/%0d/%0d want 11/40/20",
               cyc, uop, isa);
    end
    cmp++;
    if (s_cyc !== 4'd11 || s_uop !== 4'hF || s_isa !== 4'hF) begin
      err++;
      $display("FAIL count_small: got %0d/%0d/%0d want 11/15/15",
               s_cyc, s_uop, s_isa);
    end
    do_ack();
  endtask

  task automatic test_goal();
    maxCycles = 0; goalEnable = 2'b10;
    goalPC = {16'h1234, 16'h1234};
    go();
    for (int i = 1; i <= 6; i++) begin
      commit = (i == 3) ? 4'h0 : 4'h1;
      lastPC = (i == 3) ? 16'h1234 : 16'h0;
      @(negedge clk);
    end
    cmp++;
    if (running !== 1'b1 || cyc !== 48'd6) begin
      err++;
      $display("FAIL goal_pre: got run=%b cyc=%0d want 1/6",
               running, cyc);
    end
    commit = 4'h1; lastPC = 16'h1234;
    @(negedge clk);
    quiet();
    cmp++;
    if (done !== 1'b1 || reason !== 3'd1 || gidx !== 1'b1) begin
      err++;
      $display("FAIL goal_hit: got d=%b rsn=%0d idx=%0d want 1/1/1",
               done, reason, gidx);
    end
    cmp++;
    if (cyc !== 48'd7 || uop !== 48'd6) begin
      err++;
      $display("FAIL goal_cnt: got cyc=%0d uop=%0d want 7/6",
               cyc, uop);
    end
    do_ack();
  endtask

  task automatic test_priority();
    goalEnable = 2'b11; maxCycles = 3;
    goalPC = {16'h1234, 16'h1234};
    go();
    repeat (2) @(negedge clk);
    abort = 1'b1; commit = 4'h1; lastPC = 16'h1234;
    @(negedge clk);
    quiet();
    cmp++;
    if (done !== 1'b1 || reason !== 3'd3) begin
      err++;
      $display("FAIL prio_abort: got d=%b rsn=%0d want 1/3",
               done, reason);
    end
    do_ack();
    go();
    repeat (2) @(negedge clk);
    commit = 4'h1; lastPC = 16'h1234;
    @(negedge clk);
    quiet();
    cmp++;
    if (done !== 1'b1 || reason !== 3'd1 || gidx !== 1'b0) begin
      err++;
      $display("FAIL prio_goal: got d=%b rsn=%0d idx=%0d want 1/1/0",
               done, reason, gidx);
    end
    do_ack();
  endtask

  task automatic test_timeout();
    goalEnable = 2'b00; maxCycles = 5;
    go();
    repeat (4) @(negedge clk);
    cmp++;
    if (running !== 1'b1 || cyc !== 48'd4) begin
      err++;
      $display("FAIL tmo_pre: got run=%b cyc=%0d want 1/4",
               running, cyc);
    end
    @(negedge clk);
    cmp++;
    if (done !== 1'b1 || reason !== 3'd2 || cyc !== 48'd5) begin
      err++;
      $display("FAIL tmo_hit: got d=%b rsn=%0d cyc=%0d want 1/2/5",
               done, reason, cyc);
    end
    do_ack();
    maxCycles = 1;
    go();
    @(negedge clk);
    cmp++;
    if (done !== 1'b1 || reason !== 3'd2 || cyc !== 48'd1) begin
      err++;
      $display("FAIL tmo_one: got d=%b rsn=%0d cyc=%0d want 1/2/1",
               done, reason, cyc);
    end
    do_ack();
  endtask

  task automatic test_saturation();
    maxCycles = 0;
    go();
    commit = 4'hF; commitMidZero = 4'hF;
    repeat (20) @(negedge clk);
    commit = 4'h0; abort = 1'b1;
    @(negedge clk);
    quiet();
    cmp++;
    if (s_cyc !== 4'hF || s_uop !== 4'hF || s_isa !== 4'hF) begin
      err++;
      $display("FAIL sat_small: got %0h/%0h/%0h want f/f/f",
               s_cyc, s_uop, s_isa);
    end
    cmp++;
    if (cyc !== 48'd21 || uop !== 48'd80 || isa !== 48'd80) begin
      err++;
      $display("FAIL sat_wide: got %0d/%0d/%0d want 21/80/80",
               cyc, uop, isa);
    end
  endtask

  task automatic test_handshake();
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    cmp++;
    if (done !== 1'b1 || running !== 1'b0 || cyc !== 48'd21) begin
      err++;
      $display("FAIL hs_hold: got d=%b r=%b cyc=%0d want 1/0/21",
               done, running, cyc);
    end
    do_ack();
    cmp++;
    if (done !== 1'b0 || running !== 1'b0 || cyc !== 48'd21 ||
        uop !== 48'd80) begin
      err++;
      $display("FAIL hs_ack: got d=%b r=%b cyc=%0d uop=%0d want 0/0/21/80",
               done, running, cyc, uop);
    end
    go();
    cmp++;
    if (running !== 1'b1 || cyc !== 48'd0 || uop !== 48'd0) begin
      err++;
      $display("FAIL hs_start: got r=%b cyc=%0d uop=%0d want 1/0/0",
               running, cyc, uop);
    end
    ack = 1'b1; start = 1'b1; commit = 4'h1;
    repeat (2) @(negedge clk);
    quiet();
    cmp++;
    if (running !== 1'b1 || cyc !== 48'd2 || uop !== 48'd2) begin
      err++;
      $display("FAIL hs_run_ign: got r=%b cyc=%0d uop=%0d want 1/2/2",
               running, cyc, uop);
    end
  endtask

  task automatic test_async_reset();
    #2 rstOut = 1'b0;
    #1;
    cmp++;
    if ({running, done, reason, gidx} !== 6'd0 ||
        {cyc, uop, isa} !== 144'd0) begin
      err++;
      $display("FAIL async_rst: got r=%b d=%b cyc=%0d uop=%0d want 0",
               running, done, cyc, uop);
    end
    @(negedge clk);
    rstOut = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_watchdog();
    maxCycles = 0; goalEnable = 2'b00;
`ifdef RSD_COMMIT_WATCHDOG_EN
    go();
    repeat (7) @(negedge clk);
    cmp++;
    if (running !== 1'b1 || cyc !== 48'd7) begin
      err++;
      $display("FAIL wd_pre: got r=%b cyc=%0d want 1/7", running, cyc);
    end
    @(negedge clk);
    cmp++;
    if (done !== 1'b1 || reason !== 3'd4 || cyc !== 48'd8) begin
      err++;
      $display("FAIL wd_hit: got d=%b rsn=%0d cyc=%0d want 1/4/8",
               done, reason, cyc);
    end
    do_ack();
    go();
    for (int i = 1; i <= 13; i++) begin
      commit = (i == 6) ? 4'h1 : 4'h0;
      @(negedge clk);
    end
    commit = 4'h0;
    cmp++;
    if (running !== 1'b1 || cyc !== 48'd13) begin
      err++;
      $display("FAIL wd_restart: got r=%b cyc=%0d want 1/13",
               running, cyc);
    end
    @(negedge clk);
    cmp++;
    if (done !== 1'b1 || reason !== 3'd4 || cyc !== 48'd14) begin
      err++;
      $display("FAIL wd_hit2: got d=%b rsn=%0d cyc=%0d want 1/4/14",
               done, reason, cyc);
    end
    do_ack();
`else
    go();
    repeat (20) @(negedge clk);
    cmp++;
    if (running !== 1'b1 || reason !== 3'd0) begin
      err++;
      $display("FAIL no_wd: got r=%b rsn=%0d want 1/0", running, reason);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    cmp++;
    if (done !== 1'b1 || reason !== 3'd3 || cyc !== 48'd21) begin
      err++;
      $display("FAIL no_wd_abort: got d=%b rsn=%0d cyc=%0d want 1/3/21",
               done, reason, cyc);
    end
    do_ack();
`endif
  endtask

  initial begin
    rstOut = 1'b0;
    maxCycles = 0; goalEnable = 2'b00; goalPC = 32'h0;
    quiet();
    test_reset();
    test_count();
    test_goal();
    test_priority();
    test_timeout();
    test_saturation();
    test_handshake();
    test_async_reset();
    test_watchdog();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end

endmodule
